// File: rtl/lcd1602_responder_if.sv
// LCD1602 bus bundle between the display driver (master) and the responder (slave).
// Carries RS/RW/EN strobes, write data from the driver and read data back to the bus.
interface lcd1602_responder_if;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] lcd_data;
    logic [7:0] lcd_dout;
    logic       lcd_dout_oe;

    modport master (
        output LCD_RS, LCD_RW, LCD_EN, lcd_data,
        input  lcd_dout, lcd_dout_oe
    );

    modport slave (
        input  LCD_RS, LCD_RW, LCD_EN, lcd_data,
        output lcd_dout, lcd_dout_oe
    );
endinterface

// File: rtl/lcd1602_responder.sv
// HD44780-compatible responder: decodes LCD1602 bus writes/reads into DDRAM, AC and control regs.
// Ports: LCD_Clk/LCD_Rst, bus (slave), busy/ac/control outputs, overrun/cmd_err pulses, peek port.
module lcd1602_responder #(
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 80
) (
    input  logic                 LCD_Clk,
    input  logic                 LCD_Rst,
    lcd1602_responder_if.slave   bus,
    output logic                 busy,
    output logic [6:0]           ac,
    output logic                 disp_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 two_line,
    output logic                 overrun,
    output logic                 cmd_err,
    input  logic [6:0]           peek_addr,
    output logic [7:0]           peek_data
);
    localparam int DEPTH = 80;
    localparam int TOTAL = CLEAR_CYCLES + BUSY_CYCLES;
    localparam int CMAX  = (TOTAL > DEPTH) ? TOTAL : DEPTH;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [1:0] {INIT_CLR, IDLE, BUSY, CLEARING} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [6:0]      ac_d;
    logic            id, id_d;
    logic            sh, sh_d;
    logic            disp_d, cur_d, blink_d, two_d;
    logic [7:0]      dout, dout_d;
    logic            oe, oe_d;
    logic            ovr_d, err_d;
    logic            we;
    logic [6:0]      wa;
    logic [7:0]      wd;
    logic [7:0]      mem [0:DEPTH-1];

    // {EN, RS, RW, data} through a 2-FF synchronizer; en_q gives edge history
    logic [10:0]     s1, s2;
    logic            en_q;
    logic            en_s, rs_s, rw_s;
    logic [7:0]      dat_s;
    logic            rise, fall;

    assign en_s  = s2[10];
    assign rs_s  = s2[9];
    assign rw_s  = s2[8];
    assign dat_s = s2[7:0];
    assign rise  = en_s & ~en_q;
    assign fall  = ~en_s & en_q;

    assign busy            = (state != IDLE);
    assign bus.lcd_dout    = dout;
    assign bus.lcd_dout_oe = oe;

    function automatic logic [6:0] idx(input logic [6:0] a);
        return (a < 7'h40) ? a : a - 7'd24;
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
        if (inc)
            return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    function automatic logic ac_legal(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    always_ff @(posedge LCD_Clk or posedge LCD_Rst) begin
        if (LCD_Rst) begin
            s1   <= '0;
            s2   <= '0;
            en_q <= 1'b0;
        end else begin
            s1   <= {bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.lcd_data};
            s2   <= s1;
            en_q <= s2[10];
        end
    end

    always_ff @(posedge LCD_Clk or posedge LCD_Rst) begin
        if (LCD_Rst) begin
            state     <= INIT_CLR;
            cnt       <= '0;
            ac        <= '0;
            id        <= 1'b1;
            sh        <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            two_line  <= 1'b0;
            dout      <= '0;
            oe        <= 1'b0;
            overrun   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ac        <= ac_d;
            id        <= id_d;
            sh        <= sh_d;
            disp_on   <= disp_d;
            cursor_on <= cur_d;
            blink_on  <= blink_d;
            two_line  <= two_d;
            dout      <= dout_d;
            oe        <= oe_d;
            overrun   <= ovr_d;
            cmd_err   <= err_d;
        end
    end

    always_ff @(posedge LCD_Clk) begin
        if (we)
            mem[wa] <= wd;
    end

    // Nonblocking read: a colliding write in the same cycle is seen next cycle
    always_ff @(posedge LCD_Clk or posedge LCD_Rst) begin
        if (LCD_Rst)
            peek_data <= '0;
        else if (peek_addr < 7'(DEPTH))
            peek_data <= mem[peek_addr];
        else
            peek_data <= '0;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ac_d    = ac;
        id_d    = id;
        sh_d    = sh;
        disp_d  = disp_on;
        cur_d   = cursor_on;
        blink_d = blink_on;
        two_d   = two_line;
        dout_d  = dout;
        oe_d    = oe;
        ovr_d   = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        wa      = idx(ac);
        wd      = dat_s;

        unique case (state)
            INIT_CLR: begin
                we = 1'b1;
                wa = 7'(cnt);
                wd = 8'h20;
                if (cnt == CW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CLEARING: begin
                if (cnt < CW'(CLEAR_CYCLES)) begin
                    we = 1'b1;
                    wa = 7'(cnt);
                    wd = 8'h20;
                end
                if (cnt == CW'(TOTAL - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ac_d    = '0;
                    id_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            BUSY: begin
                if (cnt == CW'(BUSY_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: ;
        endcase

        if (rise && rw_s) begin
            oe_d   = 1'b1;
            dout_d = rs_s ? mem[idx(ac)] : {busy, ac};
        end

        if (fall) begin
            if (rw_s) begin
                oe_d = 1'b0;
                if (rs_s) begin
                    if (state == IDLE) begin
                        ac_d    = step(ac, id);
                        state_d = BUSY;
                        cnt_d   = '0;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end else if (state != IDLE) begin
                ovr_d = 1'b1;
            end else if (rs_s) begin
                we      = 1'b1;
                ac_d    = step(ac, id);
                state_d = BUSY;
                cnt_d   = '0;
            end else begin
                unique casez (dat_s)
                    8'b1???_????: begin
                        if (ac_legal(dat_s[6:0])) begin
                            ac_d    = dat_s[6:0];
                            state_d = BUSY;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    8'b01??_????: err_d = 1'b1;
                    8'b001?_????: begin
                        two_d   = dat_s[3];
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                    8'b0001_????: begin
                        if (!dat_s[3])
                            ac_d = step(ac, dat_s[2]);
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                    8'b0000_1???: begin
                        disp_d  = dat_s[2];
                        cur_d   = dat_s[1];
                        blink_d = dat_s[0];
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                    8'b0000_01??: begin
                        id_d    = dat_s[1];
                        sh_d    = dat_s[0];
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                    8'b0000_001?: begin
                        ac_d    = '0;
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                    8'b0000_0001: begin
                        state_d = CLEARING;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- HD44780-compatible responder on the LCD1602 bus; the receiving end of our display driver.
- Samples LCD_RS, LCD_RW, LCD_EN and lcd_data, decodes instructions and data writes, and maintains an 80-byte DDRAM image, the address counter (AC) and the control registers.
- Serves busy/AC and DDRAM reads on the bus, plus a side peek port.
- Used as the display model in system benches and as a capture block for on-chip display mirroring.

Parameters:
- BUSY_CYCLES, 4, LCD_Clk cycles busy is held after each accepted write or read-advance.
- CLEAR_CYCLES, 80, extra busy cycles for Clear Display; equals the DDRAM fill length.

Ports:
- LCD_Clk  input  1  sampling clock; at least 8x the LCD_EN toggle rate.
- LCD_Rst  input  1  asynchronous, active-high reset.
- LCD_RS  input  1  register select: 0 = instruction, 1 = data.
- LCD_RW  input  1  0 = write, 1 = read.
- LCD_EN  input  1  bus enable strobe, asynchronous to LCD_Clk.
- lcd_data  input  8  bus data from the driver.
- lcd_dout  output  8  read data returned to the bus.
- lcd_dout_oe  output  1  read-data drive enable.
- busy  output  1  busy flag.
- ac  output  7  address counter.
- disp_on, cursor_on, blink_on  output  1 each  display control bits D, C, B.
- two_line  output  1  function-set N bit.
- overrun  output  1  one-cycle pulse: a transaction arrived while busy and was dropped.
- cmd_err  output  1  one-cycle pulse: unsupported or illegal command.
- peek_addr  input  7  DDRAM index 0..79.
- peek_data  output  8  DDRAM[peek_addr], registered, 1-cycle latency.

Behaviour:
- Single clock, LCD_Clk. Reset is asynchronous, active-high, on LCD_Rst.
- Reset values:
  - ac=0, busy=1, disp_on=0, cursor_on=0, blink_on=0, two_line=0.
  - lcd_dout=0, lcd_dout_oe=0, overrun=0, cmd_err=0, peek_data=0.
  - Entry mode: I/D=1, S=0.
- Input capture: LCD_EN, LCD_RS, LCD_RW and lcd_data pass through 2-FF synchronizers. A rise is synced EN going 0->1; a fall is synced EN going 1->0. RS, RW and data are sampled from the synced copy on the fall.
- FSM states: INIT_CLR, IDLE, BUSY, CLEARING.
  - INIT_CLR (entered on reset release): writes 0x20 to DDRAM[0..79], one index per cycle, then goes to IDLE with busy=0.
  - Reset asserted mid-fill restarts the fill from index 0.
- Write transaction (fall with RW=0) in IDLE is decoded by highest set bit:
  - 1aaaaaaa: set AC to aaaaaaa. Legal only for 0x00-0x27 and 0x40-0x67; any other value leaves AC unchanged and pulses cmd_err.
  - 01xxxxxx: CGRAM address. Not modelled; pulses cmd_err and leaves all state unchanged.
  - 001DNFxx: two_line <= N. D and F are ignored.
  - 0001SRxx: S=0 moves the cursor, AC +1 if R=1 else -1, with wrap. S=1 (display shift) is accepted with no state change.
  - 00001DCB: updates disp_on, cursor_on, blink_on.
  - 000001IS: updates I/D and S.
  - 0000001x: AC=0.
  - 00000001: enters CLEARING, fills 0x20 over CLEAR_CYCLES cycles, then sets AC=0 and I/D=1.
  - 0x00: ignored; no busy period.
- Data write (RS=1, RW=0): DDRAM[idx(AC)] <= data, then AC steps by I/D with wrap.
- Index mapping: idx = AC for AC<0x40, otherwise AC-0x40+40.
- AC wrap:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
- Busy: every accepted write enters BUSY for BUSY_CYCLES cycles, then returns to IDLE. CLEARING lasts CLEAR_CYCLES+BUSY_CYCLES cycles in total.
- A write fall while not in IDLE is dropped and pulses overrun. DDRAM, AC and the registers are unchanged.
- Read (RW=1):
  - On a rise, lcd_dout_oe=1 and lcd_dout is loaded: {busy, ac} if RS=0, or DDRAM[idx(AC)] if RS=1.
  - On the fall, lcd_dout_oe=0.
  - An RS=1 read steps AC per I/D on the fall and enters BUSY.
  - Busy-flag reads are honoured in every state and never raise overrun.
- Simultaneous fall and peek: both are served; peek returns the pre-write value when the addresses collide.
- The peek port is legal in every state. peek_addr > 79 returns 0x00.

Test Plan:
- Release reset, wait 90 cycles -> busy falls after 80 fill cycles; peek 0..79 all read 0x20; ac=0.
- Write 0x38, 0x0C, 0x06, 0x80, then data 0x41 0x42 -> two_line=1; disp_on=1, cursor_on=0, blink_on=0; DDRAM[0]=0x41, DDRAM[1]=0x42; ac=0x02.
- Set AC 0xA7 (AC=0x27), write data 0x5A -> DDRAM[39]=0x5A and ac=0x40. Then entry mode 0x04 (decrement) and two data writes -> ac=0x40->0x27->0x26.
- Write 0x01 followed immediately by data 0x55 with no busy polling -> overrun pulses once; DDRAM all 0x20; ac=0.
- Write set-address 0xB0 (AC=0x30, illegal) -> cmd_err pulses; ac unchanged. Write 0x40 -> cmd_err pulses.
- Read with RS=0 during CLEARING -> lcd_dout[7]=1, lcd_dout_oe high only while EN is high. Assert LCD_Rst mid-clear -> all outputs return to reset values and the fill restarts from index 0.
